// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and constants for mdu_hilo
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam logic [4:0] ITER_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   function automatic logic is_div_op(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - unsigned restoring divider, one quotient bit per step
module mdu_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [32:0] shifted;
   logic [32:0] diff;

   // Trial subtraction: since rem < divisor, diff[32] is set exactly when the divisor does not fit.
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
   end

   // Remainder/quotient shift registers; dividend bits shift out of quo_q as quotient bits shift in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
         end else begin
            rem_q <= shifted[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; divider built only with MDU_DIV_EN
module mdu_hilo
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state_q, state_d;
   logic [1:0]  op_q;
   logic [4:0]  cnt_q;
   logic [31:0] mcand_q;
   logic [63:0] prod_q;
   logic        neg_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q, done_q, div_zero_q;
   logic        busy_d, done_d;

   logic        sgn_in, neg_a, neg_b;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum;
   logic [63:0] prod_step;
   logic [63:0] prod_fixed;
   logic        div_direct;

   // Operand magnitudes for signed ops, and one shift-add multiply step.
   always_comb begin
      sgn_in     = is_signed_op(op);
      neg_a      = sgn_in & opa[31];
      neg_b      = sgn_in & opb[31];
      abs_a      = neg_a ? (~opa + 32'd1) : opa;
      abs_b      = neg_b ? (~opb + 32'd1) : opb;
      mul_sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
      prod_step  = {mul_sum, prod_q[31:1]};
      prod_fixed = neg_q ? (~prod_q + 64'd1) : prod_q;
   end

`ifdef MDU_DIV_EN
   logic        dz_q;
   logic        neg_rem_q;
   logic        div_load, div_step;
   logic [31:0] quo, rem;
   logic [31:0] quo_fixed, rem_fixed;

   assign div_direct = is_div_op(op) && (opb == 32'd0);
   assign div_load   = (state_q == ST_IDLE) && start && is_div_op(op);
   assign div_step   = (state_q == ST_CALC) && is_div_op(op_q);
   assign quo_fixed  = neg_q ? (~quo + 32'd1) : quo;
   assign rem_fixed  = neg_rem_q ? (~rem + 32'd1) : rem;

   mdu_divider u_divider (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (quo),
      .remainder (rem)
   );

   // Divide-by-zero flag and remainder sign, captured at launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dz_q      <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (state_q == ST_IDLE && start) begin
         dz_q      <= is_div_op(op) && (opb == 32'd0);
         neg_rem_q <= neg_a;
      end
   end
`else
   assign div_direct = is_div_op(op);
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = div_direct ? ST_FIX : ST_CALC;
         ST_CALC: if (cnt_q == ITER_LAST) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_FIX);
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Multiply datapath: latch magnitudes at launch, then one multiplier bit per CALC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         neg_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  cnt_q   <= '0;
`ifdef MDU_DIV_EN
                  // Divide keeps the raw dividend here for the divide-by-zero HI value.
                  mcand_q <= is_div_op(op) ? opa : abs_a;
`else
                  mcand_q <= abs_a;
`endif
                  prod_q  <= {32'd0, abs_b};
                  neg_q   <= neg_a ^ neg_b;
               end
            end
            ST_CALC: begin
               cnt_q <= cnt_q + 5'd1;
               if (!is_div_op(op_q)) prod_q <= prod_step;
            end
            default: ;
         endcase
      end
   end

   // HI/LO and div_zero: MTHI/MTLO only in IDLE, result write-back in FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wr_hi) hi_q <= wdata;
               if (wr_lo) lo_q <= wdata;
               if (start) div_zero_q <= 1'b0;
            end
            ST_FIX: begin
               if (!is_div_op(op_q)) begin
                  {hi_q, lo_q} <= prod_fixed;
               end
`ifdef MDU_DIV_EN
               else if (dz_q) begin
                  hi_q       <= mcand_q;
                  lo_q       <= '1;
                  div_zero_q <= 1'b1;
               end else begin
                  hi_q <= rem_fixed;
                  lo_q <= quo_fixed;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo against a behavioural HI/LO model
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        rst, start, wr_hi, wr_lo;
   logic [1:0]  op;
   logic [31:0] opa, opb, wdata;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_dz = 1'b0;

   always #5 clk = ~clk;

   mdu_hilo dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi0, input logic [31:0] lo0,
                                  output logic [31:0] h, output logic [31:0] l,
                                  output logic dz, output int lat);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = hi0; l = lo0; dz = 1'b0; lat = 34;
      case (o)
         2'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         2'd1: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
         default: begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF; dz = 1'b1; lat = 2;
            end else if (o == 2'd2) begin
               l = 32'(sa / sb); h = 32'(sa % sb);
            end else begin
               l = a / b; h = a % b;
            end
`else
            lat = 2;
`endif
         end
      endcase
   endfunction

   // Launch one op from a negedge, wait for done, compare against the model; ends at the done-cycle negedge.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic wh, input logic wl, input logic [31:0] wd, input string nm);
      logic [31:0] e_hi, e_lo;
      logic e_dz;
      int e_lat, cyc, bcnt;
      if (wh) m_hi = wd;
      if (wl) m_lo = wd;
      ref_op(o, a, b, m_hi, m_lo, e_hi, e_lo, e_dz, e_lat);
      start = 1'b1; op = o; opa = a; opb = b; wr_hi = wh; wr_lo = wl; wdata = wd;
      @(posedge clk);
      cyc = 1; bcnt = 0;
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      opa = $urandom; opb = $urandom; op = 2'($urandom);
      while (done !== 1'b1 && cyc < 100) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s done timeout: got %b want 1", nm, done); end
      checks++; if (cyc != e_lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, e_lat); end
      checks++; if (hi !== e_hi) begin failures++; $display("FAIL %s hi: got %h want %h", nm, hi, e_hi); end
      checks++; if (lo !== e_lo) begin failures++; $display("FAIL %s lo: got %h want %h", nm, lo, e_lo); end
      checks++; if (div_zero !== e_dz) begin failures++; $display("FAIL %s div_zero: got %b want %b", nm, div_zero, e_dz); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_in_done: got %b want 0", nm, busy); end
      checks++; if (bcnt != e_lat - 1) begin failures++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bcnt, e_lat - 1); end
      m_hi = e_hi; m_lo = e_lo; m_dz = e_dz;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset hilo: got %h want 0", {hi, lo}); end
      checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++; $display("FAIL reset flags: got %b want 000", {busy, done, div_zero}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, "mult_7_m3");
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mult_7_m3 const: got %h want ffffffffffffffeb", {hi, lo}); end
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "multu_max");
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_max const: got %h want fffffffe00000001", {hi, lo}); end
      do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, "div_m7_2");
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "div_ovf");
      do_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, "divu_by0");
      do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, 32'd0, "div_by0_neg");
      do_op(2'd0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, "mult_clears_dz");
      do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, "mult_minmin");
   endtask

   task automatic test_mthilo();
      logic [31:0] v;
      v = $urandom;
      wr_hi = 1'b1; wdata = v;
      @(posedge clk); @(negedge clk);
      wr_hi = 1'b0;
      checks++; if (hi !== v) begin failures++; $display("FAIL mthi_idle: got %h want %h", hi, v); end
      m_hi = v;
      do_op(2'd0, $urandom, $urandom, 1'b1, 1'b1, 32'hDEAD_BEEF, "mult_with_mt");
      do_op(2'd2, $urandom, $urandom_range(1, 1000), 1'b1, 1'b0, 32'h0BAD_F00D, "div_with_mthi");
   endtask

   task automatic test_busy_ignore();
      int cyc;
      start = 1'b1; op = 2'd0; opa = 32'd3; opb = 32'd5;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && cyc < 100) begin
         start = (cyc == 5); wr_hi = (cyc == 6);
         op = 2'd3; opa = 32'd9; opb = 32'd3; wdata = 32'h0000_AAAA;
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; wr_hi = 1'b0;
      checks++; if (cyc != 34) begin failures++; $display("FAIL busy_ignore latency: got %0d want 34", cyc); end
      checks++; if ({hi, lo} !== 64'd15) begin failures++; $display("FAIL busy_ignore result: got %h want 000000000000000f", {hi, lo}); end
      checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL busy_ignore div_zero: got %b want 0", div_zero); end
      wr_lo = 1'b1; wdata = 32'h0000_1234;
      @(posedge clk); @(negedge clk);
      wr_lo = 1'b0;
      checks++; if (lo !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_after: got %h want 00001234", lo); end
      repeat (2) @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL no_queued_start: got %b want 00", {busy, done}); end
      m_hi = 32'd0; m_lo = 32'h0000_1234; m_dz = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         do_op(2'(i), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0, 1'b0, 32'd0, "back_to_back");
      end
   endtask

   task automatic test_random();
      logic [1:0] o;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         do_op(o, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, "random");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = 2'd2; opa = $urandom; opb = 32'($urandom_range(1, 50));
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = $urandom | 32'd1;
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      repeat (9) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL midreset hilo: got %h want 0", {hi, lo}); end
      checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++; $display("FAIL midreset flags: got %b want 000", {busy, done, div_zero}); end
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      @(negedge clk);
      do_op(2'd0, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0, "after_reset_mult");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
      test_reset();
      test_directed();
      test_mthilo();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
